// File: rtl/svm_regressor_seq.sv
// svm_regressor_seq: feature-serial SVM regression core.
// Each accepted vector is pushed through one shared multiply-accumulator,
// one feature per cycle. The score is then rounded and clamped to a class
// index and held until the consumer takes it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a feature vector (in_ready high)
// MAC   | accumulating weight*feature, one feature per cycle
// ROUND | round/clamp the accumulator and register score and class
// DONE  | result presented (out_valid high) until out_ready
module svm_regressor_seq #(
    parameter int                          WIDTH_A     = 4,
    parameter int                          NUM_A       = 11,
    parameter int                          COEF_W      = 8,
    parameter int                          FRAC        = 8,
    parameter int                          ACC_W       = 20,
    parameter logic [NUM_A*COEF_W-1:0]     COEFS       = '0,
    parameter logic signed [ACC_W-1:0]     BIAS        = '0,
    parameter int                          NUM_CLASSES = 10,
    parameter int                          CLS_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_A*WIDTH_A-1:0]       inp,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_W-1:0]        score,
    output logic [CLS_W-1:0]               class_out
);

    localparam int IDX_W  = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int PROD_W = WIDTH_A + 1 + COEF_W;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_A - 1);
    localparam logic [FRAC-1:0]         HALF     = FRAC'(2 ** (FRAC - 1));
    localparam logic signed [ACC_W-1:0] MAX_Q    = ACC_W'(NUM_CLASSES - 1);
    localparam logic [CLS_W-1:0]        MAX_CLS  = CLS_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {IDLE, MAC, ROUND, DONE} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [NUM_A*WIDTH_A-1:0]   x_reg;
    logic signed [ACC_W-1:0]    acc;
    logic [IDX_W-1:0]           idx;

    logic [WIDTH_A-1:0]         x_cur;
    logic [COEF_W-1:0]          w_cur;
    logic signed [PROD_W-1:0]   x_ext;
    logic signed [PROD_W-1:0]   w_ext;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;

    logic signed [ACC_W-1:0]    q_floor;
    logic signed [ACC_W-1:0]    q_round;
    logic [FRAC-1:0]            frac_bits;
    logic                       round_up;
    logic [CLS_W-1:0]           cls_clamped;

    // Handshake flags depend only on state, so no input reaches them combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // State register; reset aborts any inference in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)        state_nxt = MAC;
            MAC:     if (idx == LAST_IDX) state_nxt = ROUND;
            ROUND:                        state_nxt = DONE;
            DONE:    if (out_ready)       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Current feature/weight pair and their product. The feature is treated as
    // unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        x_cur    = x_reg[idx*WIDTH_A +: WIDTH_A];
        w_cur    = COEFS[idx*COEF_W +: COEF_W];
        x_ext    = {{(COEF_W + 1){1'b0}}, x_cur};
        w_ext    = {{(WIDTH_A + 1){w_cur[COEF_W-1]}}, w_cur};
        prod     = x_ext * w_ext;
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    end

    // Floor-then-round: only a remainder strictly above one half rounds up,
    // so an exact .5 goes down (also for negative scores). Then clamp to the class range.
    always_comb begin
        q_floor   = acc >>> FRAC;
        frac_bits = acc[FRAC-1:0];
        round_up  = (frac_bits > HALF);
        q_round   = q_floor + {{(ACC_W - 1){1'b0}}, round_up};
        if (q_round[ACC_W-1]) begin
            cls_clamped = '0;
        end else if (q_round > MAX_Q) begin
            cls_clamped = MAX_CLS;
        end else begin
            cls_clamped = q_round[CLS_W-1:0];
        end
    end

    // Datapath: capture the vector, accumulate, then latch the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg     <= '0;
            acc       <= '0;
            idx       <= '0;
            score     <= '0;
            class_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg <= inp;
                        acc   <= BIAS;
                        idx   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    idx <= idx + IDX_W'(1);
                end
                ROUND: begin
                    score     <= acc;
                    class_out <= cls_clamped;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_svm_regressor_seq.sv
// tb_svm_regressor_seq: directed checks of svm_regressor_seq over several
// coefficient/bias configurations, plus a back-to-back run against a small model.
module tb_svm_regressor_seq;

    localparam int N_DUT = 6;

    // Per-instance weights and biases (index g selects instance g).
    localparam logic [N_DUT-1:0][87:0] COEF_TAB = {
        {8'd11, 8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
        88'h0,
        {80'h0, 8'h80},
        {11{8'h10}},
        88'h0,
        88'h0
    };
    localparam logic [N_DUT-1:0][19:0] BIAS_TAB = {
        20'd0, 20'hFFF80, 20'd256, 20'd0, 20'd897, 20'd896
    };

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid  [N_DUT];
    logic               in_ready  [N_DUT];
    logic [43:0]        inp       [N_DUT];
    logic               out_valid [N_DUT];
    logic               out_ready [N_DUT];
    logic signed [19:0] score     [N_DUT];
    logic [3:0]         class_out [N_DUT];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        svm_regressor_seq #(
            .COEFS (COEF_TAB[g]),
            .BIAS  (BIAS_TAB[g])
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .inp       (inp[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .score     (score[g]),
            .class_out (class_out[g])
        );
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_score(input logic [43:0] v);
        int s = 0;
        for (int i = 0; i < 11; i++) s += (i + 1) * int'(v[i*4 +: 4]);
        return s;
    endfunction

    function automatic int model_class(input int s);
        int q = s >>> 8;
        int r = s & 255;
        if (r > 128) q++;
        if (q < 0) q = 0;
        if (q > 9) q = 9;
        return q;
    endfunction

    // Wait (bounded) for out_valid after an acceptance edge and check the result.
    task automatic wait_result(input int k, input string tag, input int exp_s, input int exp_c);
        int cyc = 0;
        while (!out_valid[k] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val({tag, "_lat"}, cyc, 12);
        check_val({tag, "_score"}, score[k], exp_s);
        check_val({tag, "_class"}, class_out[k], exp_c);
    endtask

    // One full transaction: accept, scramble inp, wait, check, handshake.
    task automatic run_one(input int k, input logic [43:0] v, input int exp_s,
                           input int exp_c, input string tag);
        inp[k]      = v;
        in_valid[k] = 1'b1;
        check_val({tag, "_in_ready"}, in_ready[k], 1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        inp[k]      = ~v;
        wait_result(k, tag, exp_s, exp_c);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check_val({tag, "_ov_clr"}, out_valid[k], 0);
        check_val({tag, "_ready_back"}, in_ready[k], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [43:0] ones;
        logic [43:0] vec;
        int          seen;
        int          prev;
        int          w;
        int          es;

        ones = {11{4'h1}};
        for (int k = 0; k < N_DUT; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            inp[k]       = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        check_val("rst_in_ready", in_ready[0], 1);
        check_val("rst_out_valid", out_valid[0], 0);
        check_val("rst_score", score[0], 0);
        check_val("rst_class", class_out[0], 0);
        check_val("rst_in_ready5", in_ready[5], 1);
        check_val("rst_out_valid5", out_valid[5], 0);

        run_one(0, 44'h0, 896, 3, "half_dn");
        run_one(1, 44'h0, 897, 4, "half_up");
        run_one(2, {11{4'hF}}, 2640, 9, "clamp_hi");
        run_one(3, 44'hF, -1664, 0, "clamp_lo");
        run_one(4, 44'h0, -128, 0, "neg_half");

        // Backpressure: result must hold while out_ready is low.
        inp[5]      = ones;
        in_valid[5] = 1'b1;
        @(posedge clk); #1;
        in_valid[5] = 1'b0;
        wait_result(5, "bp", 66, 0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                in_valid[5] = 1'b1;
                inp[5]      = {11{4'hF}};
            end else begin
                in_valid[5] = 1'b0;
            end
            @(posedge clk); #1;
            check_val("bp_ov_hold", out_valid[5], 1);
            check_val("bp_score_hold", score[5], 66);
            check_val("bp_class_hold", class_out[5], 0);
            check_val("bp_in_ready_low", in_ready[5], 0);
        end
        in_valid[5]  = 1'b0;
        out_ready[5] = 1'b1;
        @(posedge clk); #1;
        out_ready[5] = 1'b0;
        check_val("bp_release_ready", in_ready[5], 1);
        check_val("bp_release_ov", out_valid[5], 0);
        run_one(5, ones, 66, 0, "bp_next");

        // Reset during the 5th MAC cycle.
        inp[5]      = {11{4'hF}};
        in_valid[5] = 1'b1;
        @(posedge clk); #1;
        in_valid[5] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("mid_rst_in_ready", in_ready[5], 1);
        check_val("mid_rst_out_valid", out_valid[5], 0);
        check_val("mid_rst_score", score[5], 0);
        check_val("mid_rst_class", class_out[5], 0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid[5]) seen = 1;
        end
        check_val("mid_rst_no_ov", seen, 0);
        run_one(5, {11{4'hF}}, 990, 4, "rst_redo");

        // Back-to-back: in_valid and out_ready held high.
        vec          = 44'({$urandom(), $urandom()});
        inp[5]       = vec;
        in_valid[5]  = 1'b1;
        out_ready[5] = 1'b1;
        prev         = 0;
        for (int n = 0; n < 20; n++) begin
            w = 0;
            while (!out_valid[5] && w < 40) begin
                @(posedge clk); #1;
                w++;
            end
            es = model_score(vec);
            check_val("b2b_score", score[5], es);
            check_val("b2b_class", class_out[5], model_class(es));
            if (n > 0) check_val("b2b_interval", cyc_cnt - prev, 14);
            prev   = cyc_cnt;
            vec    = 44'({$urandom(), $urandom()});
            inp[5] = vec;
            @(posedge clk); #1;
        end
        in_valid[5]  = 1'b0;
        out_ready[5] = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
